// File: rtl/simplebus_burst_follower.sv
// Memory-side simplebus follower: multi-phase address, programmable read latency,
// and read/write bursts of len+1 beats with a write-beat timeout.
module simplebus_burst_follower #(
    parameter int DATA_W     = 8,
    parameter int ABUS_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int MEM_DEPTH  = 256,
    parameter int LEN_W      = 2,
    parameter int RD_LATENCY = 2,
    parameter int WR_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic              read,
    input  logic [LEN_W-1:0]  len,
    input  logic [ABUS_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dv_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              dv_out,
    output logic              dv_oe,
    output logic              busy,
    output logic              err
);
    localparam int NPH      = ADDR_W / ABUS_W;
    localparam int MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int PH_W     = (NPH > 1) ? $clog2(NPH) : 1;
    localparam int LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int TO_W     = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
    localparam int LAT_LAST = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

    typedef enum logic [2:0] {IDLE, ADDR, RWAIT, RDATA, WDATA} state_t;

    state_t              state_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat_q;
    logic [PH_W-1:0]     ph_q;
    logic [LAT_W-1:0]    lat_q;
    logic [TO_W-1:0]     to_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];
    logic [MEM_AW-1:0]   addr_d;
    logic [MEM_AW-1:0]   idx;
    logic                rd_active;
    logic                wr_en;

    // Only the low MEM_AW address bits matter, so phases shift through a
    // register no wider than the memory index.
    assign addr_d    = MEM_AW'(addr_q << ABUS_W) | MEM_AW'(address);
    assign idx       = addr_q + MEM_AW'(beat_q);
    assign rd_active = (state_q == RDATA);
    assign wr_en     = (state_q == WDATA) && dv_in;

    function automatic state_t after_addr(input logic rd);
        if (!rd)                return WDATA;
        else if (RD_LATENCY > 0) return RWAIT;
        else                    return RDATA;
    endfunction

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            ph_q    <= '0;
            lat_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    addr_q  <= MEM_AW'(address);
                    len_q   <= len;
                    beat_q  <= '0;
                    ph_q    <= PH_W'(1);
                    lat_q   <= '0;
                    to_q    <= '0;
                    state_q <= (NPH == 1) ? after_addr(read) : ADDR;
                end
                ADDR: begin
                    addr_q <= addr_d;
                    if (ph_q == PH_W'(NPH - 1)) state_q <= after_addr(read);
                    else                        ph_q    <= ph_q + 1'b1;
                end
                RWAIT: begin
                    if (lat_q == LAT_W'(LAT_LAST)) state_q <= RDATA;
                    else                           lat_q   <= lat_q + 1'b1;
                end
                RDATA: begin
                    if (beat_q == len_q) state_q <= IDLE;
                    else                 beat_q  <= beat_q + 1'b1;
                end
                WDATA: begin
                    if (dv_in) begin
                        to_q <= '0;
                        if (beat_q == len_q) state_q <= IDLE;
                        else                 beat_q  <= beat_q + 1'b1;
                    end else if (to_q == TO_W'(WR_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; contents survive a bus reset.
    always_ff @(posedge clock) begin
        if (wr_en) mem[idx] <= data_in;
    end

    assign data_out = rd_active ? mem[idx] : '0;
    assign data_oe  = rd_active;
    assign dv_oe    = rd_active;
    assign dv_out   = rd_active;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
endmodule
